// File: rtl/ucsbece154a_check_pkg.sv
// ucsbece154a_check_pkg
// Shared definitions for the run-and-check harness:
//   - FSM state encoding (RUN, CHECK, DONE)
//   - width helpers (clog2 with a minimum of one bit)
//   - default compared-value width
package ucsbece154a_check_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Index into the check table.
  function automatic int idx_width(input int num_checks);
    return clog2_min1(num_checks);
  endfunction

  // Cycle counter must be able to hold MAX_CYCLES itself.
  function automatic int cnt_width(input int max_cycles);
    return clog2_min1(max_cycles + 1);
  endfunction

  // Fail counter must be able to hold NUM_CHECKS itself.
  function automatic int fc_width(input int num_checks);
    return clog2_min1(num_checks + 1);
  endfunction

endpackage

// File: rtl/ucsbece154a_halt_detect.sv
// ucsbece154a_halt_detect
// Detects a program halt as a PC that stays unchanged for HALT_CYCLES
// consecutive cycles (e.g. a "j ." self-loop).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : 1 while the harness is in RUN; state holds otherwise
//   pc_i       : PC of the core under test
//   halted     : combinational; 1 when this cycle's edge brings the
//                repeat counter up to HALT_CYCLES
module ucsbece154a_halt_detect
  import ucsbece154a_check_pkg::*;
#(
  parameter int HALT_CYCLES = 2,
  localparam int HC_W = clog2_min1(HALT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] pc_i,
  output logic        halted
);

  localparam logic [HC_W-1:0] HC_MAX = HC_W'(HALT_CYCLES);

  logic [31:0]     prev_pc_r;
  logic            valid_r;    // prev_pc_r holds a real PC (not the reset value)
  logic [HC_W-1:0] cnt_r;
  logic [HC_W-1:0] cnt_next_s;
  logic            repeat_s;

  // Next repeat count (saturating) and halt decision.
  always_comb begin
    repeat_s = valid_r && (pc_i == prev_pc_r);
    if (repeat_s) begin
      if (cnt_r == HC_MAX) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + HC_W'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
    halted = en && (cnt_next_s == HC_MAX);
  end

  // PC history and repeat counter; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_r <= 32'd0;
      valid_r   <= 1'b0;
      cnt_r     <= '0;
    end else if (en) begin
      prev_pc_r <= pc_i;
      valid_r   <= 1'b1;
      cnt_r     <= cnt_next_s;
    end
  end

endmodule

// File: rtl/ucsbece154a_run_checker.sv
// ucsbece154a_run_checker
// Times a program run on the core under test, then walks a table of
// architectural values comparing actual against expected, one entry per
// cycle, and reports the verdict.
// Optional macro UCSBECE154A_CHECK_MASK_EN adds chk_mask_i; a compare then
// only considers bits set in the mask (mask 0 = don't-care entry).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   pc_i          : PC of the core under test (halt detection)
//   stall_o       : freezes core state while checking / done
//   chk_idx_o     : table index under comparison
//   chk_actual_i  : actual value for chk_idx_o (combinational lookup)
//   chk_expect_i  : expected value for chk_idx_o (combinational lookup)
//   chk_mask_i    : compare mask (only with UCSBECE154A_CHECK_MASK_EN)
//   done_o        : checking finished
//   pass_o        : valid with done_o; no mismatch and no timeout
//   timeout_o     : budget ran out before a halt (HALT_DETECT=1 only)
//   fail_count_o  : number of mismatching entries
//   first_fail_o  : index of the first mismatch, 0 if none
//   cycles_o      : cycles spent in RUN
module ucsbece154a_run_checker
  import ucsbece154a_check_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_CHECKS  = 9,
  parameter int MAX_CYCLES  = 20,
  parameter int HALT_DETECT = 1,
  parameter int HALT_CYCLES = 2,
  localparam int IDX_W = idx_width(NUM_CHECKS),
  localparam int CNT_W = cnt_width(MAX_CYCLES),
  localparam int FC_W  = fc_width(NUM_CHECKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_i,
  output logic              stall_o,
  output logic [IDX_W-1:0]  chk_idx_o,
  input  logic [DATA_W-1:0] chk_actual_i,
  input  logic [DATA_W-1:0] chk_expect_i,
`ifdef UCSBECE154A_CHECK_MASK_EN
  input  logic [DATA_W-1:0] chk_mask_i,
`endif
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [FC_W-1:0]   fail_count_o,
  output logic [IDX_W-1:0]  first_fail_o,
  output logic [CNT_W-1:0]  cycles_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [FC_W-1:0]  FC_MAX   = {FC_W{1'b1}};

  state_t           state_r;
  logic             stall_r;
  logic [IDX_W-1:0] chk_idx_r;
  logic             done_r;
  logic             pass_r;
  logic             timeout_r;
  logic [FC_W-1:0]  fail_count_r;
  logic [IDX_W-1:0] first_fail_r;
  logic [CNT_W-1:0] cycles_r;

  logic             halted_s;
  logic             mismatch_s;
  logic [FC_W-1:0]  fail_next_s;
  logic [CNT_W-1:0] cycles_next_s;

  ucsbece154a_halt_detect #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt_detect (
    .clk   (clk),
    .reset (reset),
    .en    (state_r == ST_RUN),
    .pc_i  (pc_i),
    .halted(halted_s)
  );

  // Compare datapath and next values of the counters.
  always_comb begin
`ifdef UCSBECE154A_CHECK_MASK_EN
    mismatch_s = (((chk_actual_i ^ chk_expect_i) & chk_mask_i) != '0);
`else
    mismatch_s = (chk_actual_i != chk_expect_i);
`endif
    if (mismatch_s && (fail_count_r != FC_MAX)) begin
      fail_next_s = fail_count_r + FC_W'(1);
    end else begin
      fail_next_s = fail_count_r;
    end
    // Only used in RUN, where cycles_r < MAX_CYCLES, so this never wraps.
    cycles_next_s = cycles_r + CNT_W'(1);
  end

  // RUN -> CHECK -> DONE sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_RUN;
      stall_r      <= 1'b0;
      chk_idx_r    <= '0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      fail_count_r <= '0;
      first_fail_r <= '0;
      cycles_r     <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cycles_r <= cycles_next_s;
          // Halt takes priority over budget exhaustion in the same cycle.
          if ((HALT_DETECT != 0) && halted_s) begin
            state_r   <= ST_CHECK;
            stall_r   <= 1'b1;
            timeout_r <= 1'b0;
          end else if (cycles_next_s == MAX_CNT) begin
            state_r   <= ST_CHECK;
            stall_r   <= 1'b1;
            timeout_r <= (HALT_DETECT != 0);
          end
        end
        ST_CHECK: begin
          if (mismatch_s) begin
            fail_count_r <= fail_next_s;
            if (fail_count_r == '0) begin
              first_fail_r <= chk_idx_r;
            end
          end
          if (chk_idx_r == LAST_IDX) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            pass_r  <= (fail_next_s == '0) && !timeout_r;
          end else begin
            chk_idx_r <= chk_idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          // Corrupted state: stop the core and report a failure.
          state_r <= ST_DONE;
          stall_r <= 1'b1;
          done_r  <= 1'b1;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o      = stall_r;
  assign chk_idx_o    = chk_idx_r;
  assign done_o       = done_r;
  assign pass_o       = pass_r;
  assign timeout_o    = timeout_r;
  assign fail_count_o = fail_count_r;
  assign first_fail_o = first_fail_r;
  assign cycles_o     = cycles_r;

endmodule

// File: tb/tb_ucsbece154a_run_checker.sv
// Directed testbench for ucsbece154a_run_checker.
// Instance a: HALT_DETECT=1; instance b: HALT_DETECT=0. Each is driven by a
// tiny PC model: PC steps by 4 per unstalled cycle and either parks at 0x40
// ("j .") or keeps going (looping program).
module tb_ucsbece154a_run_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic        reset_a = 1'b1, reset_b = 1'b1;
  logic        loop_a = 1'b0;
  logic [31:0] pc_a, pc_b;

  logic        stall_a, done_a, pass_a, timeout_a;
  logic [3:0]  idx_a, first_a, fc_a;
  logic [4:0]  cyc_a;
  logic        stall_b, done_b, pass_b, timeout_b;
  logic [3:0]  idx_b, first_b, fc_b;
  logic [4:0]  cyc_b;

  logic [31:0] act_tbl [0:15];
  logic [31:0] exp_tbl [0:15];
  logic [31:0] act_a, exp_a, act_b, exp_b;

  assign act_a = act_tbl[idx_a];
  assign exp_a = exp_tbl[idx_a];
  assign act_b = act_tbl[idx_b];
  assign exp_b = exp_tbl[idx_b];

`ifdef UCSBECE154A_CHECK_MASK_EN
  logic [31:0] mask_tbl [0:15];
  logic [31:0] mask_a, mask_b;
  assign mask_a = mask_tbl[idx_a];
  assign mask_b = mask_tbl[idx_b];
`endif

  // Core PC models.
  always_ff @(posedge clk) begin
    if (reset_a) pc_a <= 32'd0;
    else if (!stall_a) pc_a <= (!loop_a && pc_a == 32'h40) ? pc_a : pc_a + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (reset_b) pc_b <= 32'd0;
    else if (!stall_b) pc_b <= (pc_b == 32'h40) ? pc_b : pc_b + 32'd4;
  end

  ucsbece154a_run_checker #(.DATA_W(32), .NUM_CHECKS(9), .MAX_CYCLES(20),
                            .HALT_DETECT(1), .HALT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset_a), .pc_i(pc_a), .stall_o(stall_a),
    .chk_idx_o(idx_a), .chk_actual_i(act_a), .chk_expect_i(exp_a),
`ifdef UCSBECE154A_CHECK_MASK_EN
    .chk_mask_i(mask_a),
`endif
    .done_o(done_a), .pass_o(pass_a), .timeout_o(timeout_a),
    .fail_count_o(fc_a), .first_fail_o(first_a), .cycles_o(cyc_a));

  ucsbece154a_run_checker #(.DATA_W(32), .NUM_CHECKS(9), .MAX_CYCLES(20),
                            .HALT_DETECT(0), .HALT_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset_b), .pc_i(pc_b), .stall_o(stall_b),
    .chk_idx_o(idx_b), .chk_actual_i(act_b), .chk_expect_i(exp_b),
`ifdef UCSBECE154A_CHECK_MASK_EN
    .chk_mask_i(mask_b),
`endif
    .done_o(done_b), .pass_o(pass_b), .timeout_o(timeout_b),
    .fail_count_o(fc_b), .first_fail_o(first_b), .cycles_o(cyc_b));

  // Table: sp, tp, gp, t0, t2, RAM[24], RAM[25], RAM[26], zero.
  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin
      act_tbl[i] = 32'd0;
`ifdef UCSBECE154A_CHECK_MASK_EN
      mask_tbl[i] = 32'hFFFF_FFFF;
`endif
    end
    act_tbl[0] = 32'h0BEE_F000; act_tbl[1] = 32'h1;  act_tbl[2] = 32'h44;
    act_tbl[3] = 32'hB;         act_tbl[4] = 32'h7;  act_tbl[5] = 32'h7;
    act_tbl[6] = 32'h19;        act_tbl[7] = 32'h0BEE_F000; act_tbl[8] = 32'h0;
    for (int i = 0; i < 16; i++) exp_tbl[i] = act_tbl[i];
  endtask

  task automatic reset_a_seq();
    reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_a = 1'b0;
  endtask

  // Run instance a until stall_o rises; returns 1 when it did.
  task automatic wait_stall_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (stall_a) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL stall_a_wait: stall_o never rose"); end
  endtask

  // Count edges from CHECK entry until done_o on instance a.
  task automatic wait_done_a(output int n);
    n = 0;
    while (!done_a && n < 30) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!done_a) begin tests_failed++; $display("FAIL done_a_wait: done_o never rose"); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    tests_run++;
    if ({stall_a, done_a, pass_a, timeout_a, fc_a, first_a, cyc_a, idx_a} !== 21'd0) begin
      tests_failed++; $display("FAIL reset_a: outputs %h expected 0",
        {stall_a, done_a, pass_a, timeout_a, fc_a, first_a, cyc_a, idx_a});
    end
    tests_run++;
    if ({stall_b, done_b, pass_b, timeout_b, fc_b, first_b, cyc_b, idx_b} !== 21'd0) begin
      tests_failed++; $display("FAIL reset_b: outputs %h expected 0",
        {stall_b, done_b, pass_b, timeout_b, fc_b, first_b, cyc_b, idx_b});
    end
  endtask

  task automatic test_halt_pass();
    bit ok; int n;
    init_tables(); loop_a = 1'b0;
    reset_a_seq();
    wait_stall_a(ok);
    // PC reaches 0x40 in RUN cycle 17; repeats in 18 and 19 -> halt at 19.
    tests_run++;
    if (cyc_a !== 5'd19) begin tests_failed++; $display("FAIL halt_cycles: got %0d expected 19", cyc_a); end
    tests_run++;
    if (idx_a !== 4'd0 || done_a !== 1'b0) begin tests_failed++; $display("FAIL halt_check_entry: idx %0d done %b expected 0 0", idx_a, done_a); end
    wait_done_a(n);
    tests_run++;
    if (n !== 9) begin tests_failed++; $display("FAIL halt_latency: got %0d expected 9", n); end
    tests_run++;
    if ({pass_a, timeout_a, fc_a, first_a, idx_a} !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd8}) begin
      tests_failed++; $display("FAIL halt_verdict: pass %b to %b fc %0d ff %0d idx %0d expected 1 0 0 0 8",
        pass_a, timeout_a, fc_a, first_a, idx_a);
    end
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if ({done_a, stall_a, pass_a, cyc_a} !== {1'b1, 1'b1, 1'b1, 5'd19}) begin
      tests_failed++; $display("FAIL done_hold: done %b stall %b pass %b cyc %0d expected 1 1 1 19",
        done_a, stall_a, pass_a, cyc_a);
    end
  endtask

  task automatic test_mismatch();
    bit ok; int n;
    init_tables();
    exp_tbl[2] = 32'h45; exp_tbl[6] = 32'h18;
    reset_a_seq();
    wait_stall_a(ok);
    wait_done_a(n);
    tests_run++;
    if ({pass_a, timeout_a, fc_a, first_a} !== {1'b0, 1'b0, 4'd2, 4'd2}) begin
      tests_failed++; $display("FAIL mismatch_verdict: pass %b to %b fc %0d ff %0d expected 0 0 2 2",
        pass_a, timeout_a, fc_a, first_a);
    end
    init_tables();
  endtask

  task automatic test_budget();
    bit ok; int n;
    init_tables(); loop_a = 1'b1;
    reset_a_seq();
    wait_stall_a(ok);
    tests_run++;
    if (cyc_a !== 5'd20 || timeout_a !== 1'b1) begin
      tests_failed++; $display("FAIL budget_entry: cyc %0d to %b expected 20 1", cyc_a, timeout_a);
    end
    wait_done_a(n);
    tests_run++;
    if ({pass_a, timeout_a, fc_a, cyc_a} !== {1'b0, 1'b1, 4'd0, 5'd20}) begin
      tests_failed++; $display("FAIL budget_verdict: pass %b to %b fc %0d cyc %0d expected 0 1 0 20",
        pass_a, timeout_a, fc_a, cyc_a);
    end
    loop_a = 1'b0;
  endtask

  task automatic test_no_halt_detect();
    bit ok; int n;
    init_tables();
    reset_b = 1'b1; repeat (2) @(posedge clk); #1 reset_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin @(posedge clk); #1; if (stall_b) ok = 1'b1; end
    tests_run++;
    if (!ok || cyc_b !== 5'd20 || timeout_b !== 1'b0) begin
      tests_failed++; $display("FAIL nohalt_entry: stall %b cyc %0d to %b expected 1 20 0", stall_b, cyc_b, timeout_b);
    end
    n = 0;
    while (!done_b && n < 30) begin @(posedge clk); #1; n++; end
    tests_run++;
    if ({done_b, pass_b, timeout_b, fc_b, cyc_b} !== {1'b1, 1'b1, 1'b0, 4'd0, 5'd20} || n !== 9) begin
      tests_failed++; $display("FAIL nohalt_verdict: done %b pass %b to %b fc %0d cyc %0d lat %0d expected 1 1 0 0 20 9",
        done_b, pass_b, timeout_b, fc_b, cyc_b, n);
    end
  endtask

  task automatic test_reset_mid_check();
    bit ok; int n;
    init_tables();
    reset_a_seq();
    wait_stall_a(ok);
    n = 0;
    while (idx_a !== 4'd4 && n < 20) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (idx_a !== 4'd4) begin tests_failed++; $display("FAIL midchk_reach: idx %0d expected 4", idx_a); end
    reset_a = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({stall_a, done_a, pass_a, timeout_a, fc_a, first_a, cyc_a, idx_a} !== 21'd0) begin
      tests_failed++; $display("FAIL midchk_reset: outputs %h expected 0",
        {stall_a, done_a, pass_a, timeout_a, fc_a, first_a, cyc_a, idx_a});
    end
    reset_a = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (cyc_a !== 5'd1 || stall_a !== 1'b0) begin tests_failed++; $display("FAIL midchk_restart: cyc %0d stall %b expected 1 0", cyc_a, stall_a); end
    wait_stall_a(ok);
    wait_done_a(n);
    tests_run++;
    if ({pass_a, fc_a, cyc_a} !== {1'b1, 4'd0, 5'd19}) begin
      tests_failed++; $display("FAIL midchk_rerun: pass %b fc %0d cyc %0d expected 1 0 19", pass_a, fc_a, cyc_a);
    end
  endtask

  task automatic test_mask();
    bit ok; int n;
    init_tables();
    exp_tbl[0] = 32'h0BEE_F0FF;
`ifdef UCSBECE154A_CHECK_MASK_EN
    mask_tbl[0] = 32'h0FFF_FF00;
    reset_a_seq(); wait_stall_a(ok); wait_done_a(n);
    tests_run++;
    if ({pass_a, fc_a} !== {1'b1, 4'd0}) begin tests_failed++; $display("FAIL mask_dontcare: pass %b fc %0d expected 1 0", pass_a, fc_a); end
    mask_tbl[0] = 32'h0FFF_FFFF;
`endif
    reset_a_seq(); wait_stall_a(ok); wait_done_a(n);
    tests_run++;
    if ({pass_a, fc_a, first_a} !== {1'b0, 4'd1, 4'd0}) begin
      tests_failed++; $display("FAIL mask_full: pass %b fc %0d ff %0d expected 0 1 0", pass_a, fc_a, first_a);
    end
    init_tables();
  endtask

  initial begin
    init_tables();
    test_reset();
    reset_b = 1'b1;
    test_halt_pass();
    test_mismatch();
    test_budget();
    test_no_halt_detect();
    test_reset_mid_check();
    test_mask();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
